// File: rtl/ifmap_fetch_pkg.sv
// Shared FSM state encoding and data width for the ifmap fetch block.
package ifmap_fetch_pkg;
   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/ifmap_fetch_vec.sv
// Two-entry vector FIFO: registered write, head visible the cycle after push.
// Push and pop in the same cycle are allowed; a push into a full FIFO without a pop is dropped.
module vec_fifo
   import ifmap_fetch_pkg::*;
#(
   parameter int INPUTS_MAC = 6
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  push,
   input  logic [INPUTS_MAC-1:0][DATA_BITS-1:0]  push_data,
   input  logic                                  pop,
   output logic [INPUTS_MAC-1:0][DATA_BITS-1:0]  head,
   output logic                                  not_empty,
   output logic [1:0]                            count
);
   logic [INPUTS_MAC-1:0][DATA_BITS-1:0] mem [2];
   logic rd_ptr;
   logic wr_ptr;
   logic do_push;
   logic do_pop;

   assign do_pop    = pop && (count != 2'd0);
   assign do_push   = push && ((count != 2'd2) || do_pop);
   assign not_empty = (count != 2'd0);
   assign head      = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/ifmap_fetch.sv
// Streams num_beats ifmap vectors to the MAC array; first vector 2 cycles after start.
// At most two beats are buffered or in flight; vec_ready low stalls address issue.
module ifmap_fetch
   import ifmap_fetch_pkg::*;
#(
   parameter int ADDRESS_BITS = 8,
   parameter int INPUTS_MAC   = 6,
   parameter int LEN_BITS     = 8
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic [ADDRESS_BITS-1:0]                 base_addr,
   input  logic [LEN_BITS-1:0]                     num_beats,
   output logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] if_address,
   input  logic [INPUTS_MAC-1:0][DATA_BITS-1:0]    ifmap_r,
   output logic [INPUTS_MAC-1:0][DATA_BITS-1:0]    vec_data,
   output logic                                    vec_valid,
   input  logic                                    vec_ready,
   output logic                                    busy,
   output logic                                    done
);
   state_t state_q;
   state_t state_d;

   logic [ADDRESS_BITS-1:0]                 next_addr_q;
   logic [ADDRESS_BITS-1:0]                 issue_base;
   logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] addr_hold_q;
   logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] beat_addr;
   logic [LEN_BITS-1:0]                     beats_q;
   logic [LEN_BITS-1:0]                     issued_q;
   logic [LEN_BITS-1:0]                     delivered_q;
   logic                                    inflight_q;
   logic [1:0]                              fifo_count;
   logic [2:0]                              occ;
   logic                                    issue;
   logic                                    pop;
   logic                                    last_issue;
   logic                                    last_pop;

   vec_fifo #(
      .INPUTS_MAC(INPUTS_MAC)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (ifmap_r),
      .pop       (pop),
      .head      (vec_data),
      .not_empty (vec_valid),
      .count     (fifo_count)
   );

   assign pop        = vec_valid && vec_ready;
   // Occupancy after this cycle's pop, so a streaming consumer never sees a bubble.
   assign occ        = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
   assign last_issue = (issued_q == beats_q - LEN_BITS'(1));
   assign last_pop   = pop && (delivered_q == beats_q - LEN_BITS'(1));
   // Beat 0 issues straight from the start inputs to meet the 2-cycle first-vector latency.
   assign issue_base = (state_q == IDLE) ? base_addr : next_addr_q;
   assign if_address = issue ? beat_addr : addr_hold_q;

   always_comb begin
      beat_addr = '0;
      for (int i = 0; i < INPUTS_MAC; i++) begin
         beat_addr[i] = issue_base + ADDRESS_BITS'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_beats == '0) begin
                  state_d = DONE;
               end else begin
                  issue   = 1'b1;
                  state_d = (num_beats == LEN_BITS'(1)) ? DRAIN : FETCH;
               end
            end
         end
         FETCH: begin
            busy = 1'b1;
            if (occ < 3'd2) begin
               issue = 1'b1;
               if (last_issue) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_pop) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         addr_hold_q <= '0;
         beats_q     <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (issue) begin
            addr_hold_q <= beat_addr;
            next_addr_q <= issue_base + ADDRESS_BITS'(INPUTS_MAC);
            issued_q    <= (state_q == IDLE) ? LEN_BITS'(1) : issued_q + LEN_BITS'(1);
         end
         if ((state_q == IDLE) && start) begin
            beats_q     <= num_beats;
            delivered_q <= '0;
         end else if (pop) begin
            delivered_q <= delivered_q + LEN_BITS'(1);
         end
      end
   end
endmodule

// File: tb/tb_ifmap_fetch.sv
// Scoreboard bench for ifmap_fetch: byte-addressed memory model, queue of expected vectors.
module tb_ifmap_fetch;
   localparam int AB = 8;
   localparam int M  = 6;
   localparam int LB = 8;

   typedef logic [M-1:0][7:0] vec_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [AB-1:0]      base_addr = '0;
   logic [LB-1:0]      num_beats = '0;
   logic [M-1:0][AB-1:0] if_address;
   logic [M-1:0][7:0]  ifmap_r = '0;
   logic [M-1:0][7:0]  vec_data;
   logic               vec_valid;
   logic               vec_ready = 1'b0;
   logic               busy;
   logic               done;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_count = 0;
   int   job_hs = 0;
   int   job_beats = 0;
   int   first_hs = -1;
   int   last_hs = -1;
   int   start_cyc = 0;
   bit   busy_seen = 0;
   bit   real_start = 0;
   int   ready_mode = 0;
   int   pat_idx = 0;
   logic [7:0] key = 8'h00;
   vec_t exp_q[$];
   vec_t mon_v;

   ifmap_fetch #(.ADDRESS_BITS(AB), .INPUTS_MAC(M), .LEN_BITS(LB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
      .if_address(if_address), .ifmap_r(ifmap_r), .vec_data(vec_data), .vec_valid(vec_valid),
      .vec_ready(vec_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Memory with 1-cycle read latency; contents are an address-unique byte pattern.
   always @(posedge clk) begin
      for (int i = 0; i < M; i++) ifmap_r[i] <= if_address[i] ^ key;
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: vec_ready = 1'b1;
         1: vec_ready = 1'($urandom_range(0, 1));
         2: begin vec_ready = (pat_idx == 0); pat_idx = (pat_idx + 1) % 3; end
         default: vec_ready = 1'b0;
      endcase
   end

   task automatic check_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (start && real_start) start_cyc = cyc;
         if (busy) busy_seen = 1;
         check_eq("occ_plus_inflight_le_2",
                  longint'(int'(dut.u_fifo.count) + int'(dut.inflight_q) > 2), 0);
         if (vec_valid && vec_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_vector actual=%0h expected=none", vec_data);
            end else begin
               mon_v = exp_q.pop_front();
               check_eq("vec_data", longint'(vec_data), longint'(mon_v));
            end
            if (job_hs == 0) first_hs = cyc;
            last_hs = cyc;
            job_hs++;
         end
         if (done) begin
            done_count++;
            check_eq("busy_during_done", longint'(busy), 0);
            check_eq("done_timing", cyc, (job_beats == 0) ? start_cyc + 1 : last_hs + 1);
         end
      end
   end

   task automatic run_job(input int base, input int nb, input bit chk_addr, input bit repulse);
      int   d0;
      int   t;
      vec_t v;
      for (int k = 0; k < nb; k++) begin
         for (int i = 0; i < M; i++) v[i] = 8'((base + k * M + i) % 256) ^ key;
         exp_q.push_back(v);
      end
      d0 = done_count;
      @(posedge clk); #1;
      job_beats = nb; job_hs = 0; busy_seen = 0; first_hs = -1;
      start = 1'b1; real_start = 1'b1; base_addr = AB'(base); num_beats = LB'(nb);
      if (chk_addr) begin
         for (int k = 0; k < 3 && k < nb; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 1) begin
               start = 1'b0; real_start = 1'b0;
               base_addr = AB'($urandom); num_beats = LB'($urandom);
            end
            #1;
            for (int i = 0; i < M; i++)
               check_eq("if_address", longint'(if_address[i]), longint'((base + k * M + i) % 256));
         end
      end
      if (start) begin
         @(posedge clk); #1;
         start = 1'b0; real_start = 1'b0;
         base_addr = AB'($urandom); num_beats = LB'($urandom);
      end
      if (repulse) begin
         @(posedge clk); #1;
         start = 1'b1; base_addr = AB'($urandom); num_beats = LB'($urandom_range(1, 9));
         @(posedge clk); #1;
         start = 1'b0;
      end
      t = 0;
      while (done_count == d0 && t < 400) begin @(posedge clk); t++; end
      check_eq("job_timeout", longint'(t >= 400), 0);
      repeat (6) @(posedge clk);
      check_eq("done_pulses", done_count - d0, 1);
      check_eq("vectors_delivered", job_hs, nb);
      check_eq("pending_expected", exp_q.size(), 0);
      if (nb == 0) check_eq("busy_zero_job", longint'(busy_seen), 0);
      if (chk_addr && nb > 0) begin
         check_eq("first_vec_latency", first_hs - start_cyc, 2);
         check_eq("last_vec_cycle", last_hs - start_cyc, nb + 1);
      end
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      key = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_vec_valid", longint'(vec_valid), 0);
      check_eq("reset_busy", longint'(busy), 0);
      check_eq("reset_done", longint'(done), 0);
      check_eq("reset_if_address", longint'(if_address), 0);
      check_eq("reset_vec_data", longint'(vec_data), 0);
      rst = 1'b1;

      ready_mode = 0;
      run_job(2, 3, 1, 0);
      run_job(250, 2, 1, 0);
      run_job(77, 0, 0, 0);
      ready_mode = 2; pat_idx = 0;
      run_job(40, 4, 0, 0);

      // Mid-job reset after the second beat has issued.
      ready_mode = 3;
      d0 = done_count;
      @(posedge clk); #1;
      job_beats = 4; job_hs = 0;
      start = 1'b1; real_start = 1'b1; base_addr = 8'd100; num_beats = 8'd4;
      @(posedge clk); #1;
      start = 1'b0; real_start = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check_eq("midreset_vec_valid", longint'(vec_valid), 0);
      check_eq("midreset_busy", longint'(busy), 0);
      check_eq("midreset_done", longint'(done), 0);
      check_eq("midreset_if_address", longint'(if_address), 0);
      check_eq("midreset_vec_data", longint'(vec_data), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      ready_mode = 0;
      repeat (3) @(posedge clk);
      check_eq("midreset_no_done", done_count - d0, 0);
      run_job(9, 5, 1, 0);

      ready_mode = 1;
      run_job(120, 6, 0, 1);
      for (int j = 0; j < 12; j++) begin
         run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifmap_fetch.md
IFMAP_FETCH -- requirements
Module: ifmap_fetch

Interface
REQ-001 Parameter ADDRESS_BITS, default 8, sets the width of the ifmap memory address.
REQ-002 Parameter INPUTS_MAC, default 6, sets the number of MAC input lanes and the number of addresses issued per beat.
REQ-003 Parameter LEN_BITS, default 8, sets the width of the beat count.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse that launches a fetch job.
REQ-007 Port base_addr, input, ADDRESS_BITS: address of lane 0 of beat 0, sampled when start is accepted.
REQ-008 Port num_beats, input, LEN_BITS: number of vectors in the job, sampled when start is accepted.
REQ-009 Port if_address, output, INPUTS_MAC x ADDRESS_BITS: read addresses driven to the ifmap memory.
REQ-010 Port ifmap_r, input, INPUTS_MAC x 8: read data returned by the memory.
REQ-011 Port vec_data, output, INPUTS_MAC x 8: vector presented to the MAC array.
REQ-012 Port vec_valid, output, 1 bit: vec_data holds a valid vector.
REQ-013 Port vec_ready, input, 1 bit: the MAC array accepts the vector.
REQ-014 Port busy, output, 1 bit: a job is in progress.
REQ-015 Port done, output, 1 bit: one-cycle pulse marking job completion.

Function
REQ-016 The memory read latency SHALL be fixed at 1 cycle: an address driven in cycle n returns its data on ifmap_r in cycle n+1.
REQ-017 Lane i of beat k SHALL be read at address (base_addr + k*INPUTS_MAC + i) mod 2^ADDRESS_BITS, so addresses wrap without error.
REQ-018 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE.
REQ-019 In IDLE, start SHALL latch base_addr and num_beats, then move to FETCH; if num_beats = 0 it SHALL move directly to DONE.
REQ-020 In FETCH, a beat SHALL issue only while FIFO occupancy plus reads in flight is less than 2; each issue increments the issued-beat counter.
REQ-021 After the last beat issues, the FSM SHALL move to DRAIN.
REQ-022 DRAIN SHALL move to DONE in the cycle in which the last vector handshake (vec_valid and vec_ready both high) occurs.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Returned data SHALL be written into a 2-entry FIFO exactly 1 cycle after issue.
REQ-025 vec_valid SHALL equal FIFO not-empty, and vec_data SHALL be the FIFO head.
REQ-026 The FIFO SHALL support a push and a pop in the same cycle.
REQ-027 A vector SHALL never be dropped or duplicated under any vec_ready pattern.
REQ-028 With vec_ready held high, one vector SHALL be delivered per cycle; the first vec_valid appears 2 cycles after start.
REQ-029 busy SHALL be high in FETCH and DRAIN and low in IDLE and DONE.
REQ-030 start SHALL be ignored while not in IDLE.
REQ-031 if_address SHALL hold its last value when not issuing.

Reset
REQ-032 Asserting rst low SHALL immediately force the state to IDLE, clear the counters and FIFO, and drive vec_valid, busy and done to 0, if_address to 0 and vec_data to 0.
REQ-033 A reset mid-job SHALL abandon the job, and data returning after reset SHALL be discarded.

Structure
REQ-034 A shared package ifmap_fetch_pkg SHALL hold the FSM state enum and the DATA_BITS = 8 constant.
REQ-035 The 2-entry FIFO SHALL be a sub-module named vec_fifo, parameterised by INPUTS_MAC.

Verification
REQ-036 Scenario: base=2, num_beats=3, INPUTS_MAC=6, vec_ready=1 -> if_address sequences 2..7, 8..13, 14..19; three vectors on consecutive cycles; done 1 cycle after the third.
REQ-037 Scenario: base=250, num_beats=2 -> beat 0 addresses 250..255, beat 1 addresses 0..5 (wrap).
REQ-038 Scenario: num_beats=0 -> no vec_valid; done pulses 1 cycle after start; busy stays 0.
REQ-039 Scenario: num_beats=4 with vec_ready toggling 1,0,0,1,... -> all 4 vectors delivered in order with correct data; occupancy plus in-flight never exceeds 2.
REQ-040 Scenario: rst pulsed low after the second issue -> outputs immediately 0; a new start afterwards completes a fresh job correctly.
REQ-041 Scenario: start re-pulsed while busy -> ignored; exactly num_beats vectors are delivered and exactly one done pulse occurs.
